// File: rtl/traffic_pkg.sv
// Shared types and default sizing for the traffic queue sensor.
package traffic_pkg;

  // Per-lane service state: waiting for green, or timing a departure
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } lane_state_t;

  localparam int CNT_W_DEFAULT         = 4;
  localparam int DEPART_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/lane_queue.sv
// One traffic lane: arrival synchronizer, rising-edge detect, saturating
// queue counter and the departure FSM driven by the lane's green light.
// Optional sticky overflow flag built only when TRAFFIC_QUEUE_OVF_EN is defined;
// otherwise ovf is tied low and the counter still saturates.
module lane_queue
  import traffic_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int DEPART_CYCLES = DEPART_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             arrive,
  input  logic             lite,
  input  logic             fault,
  output logic [CNT_W-1:0] count,
  output logic             car,
  output logic             ovf
);

  localparam int TMR_W = 4;
  localparam logic [TMR_W-1:0] RELOAD  = TMR_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             sync_prev;
  logic             rise;
  lane_state_t      state;
  lane_state_t      state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             depart;
  logic [CNT_W-1:0] count_dep;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= arrive;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

  // Count after a departure; a simultaneous arrival cancels the departure
  assign count_dep = count - CNT_ONE + CNT_W'(rise);

  // FSM state and departure timer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state logic: start serving on green, time each car, abort on red or fault
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    depart    = 1'b0;
    case (state)
      IDLE: begin
        if (lite && !fault && count != '0) begin
          state_nxt = SERVE;
          timer_nxt = RELOAD;
        end
      end
      SERVE: begin
        if (!lite || fault || count == '0) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == '0) begin
          depart = 1'b1;
          if (count_dep != '0) begin
            timer_nxt = RELOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Queue depth: departures win over arrivals, arrivals at full are dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (depart) begin
      count <= count_dep;
    end else if (rise && count != CNT_MAX) begin
      count <= count + CNT_ONE;
    end
  end

  assign car = (count != '0);

`ifdef TRAFFIC_QUEUE_OVF_EN
  logic ovf_q;

  // Sticky flag: an arrival was lost because the queue was already full
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (rise && !depart && count == CNT_MAX) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/traffic_queue_sensor.sv
// Traffic queue sensor top: two lane_queue instances (EW and NS) and the
// sticky illegal-light detector. Lights equal (both green or both red)
// blocks all departures while it lasts.
// Optional feature macro: TRAFFIC_QUEUE_OVF_EN (per-lane overflow flags).
module traffic_queue_sensor
  import traffic_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int DEPART_CYCLES = DEPART_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ew_arrive,
  input  logic             ns_arrive,
  input  logic             EWLite,
  input  logic             NSLite,
  output logic             EWCar,
  output logic             NSCar,
  output logic [CNT_W-1:0] ew_count,
  output logic [CNT_W-1:0] ns_count,
  output logic             ew_ovf,
  output logic             ns_ovf,
  output logic             lite_fault
);

  logic fault_now;

  assign fault_now = (EWLite == NSLite);

  // Remember any edge on which the light controller showed an illegal pair
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lite_fault <= 1'b0;
    end else if (fault_now) begin
      lite_fault <= 1'b1;
    end
  end

  lane_queue #(
    .CNT_W         (CNT_W),
    .DEPART_CYCLES (DEPART_CYCLES)
  ) u_ew (
    .clock   (clock),
    .reset_n (reset_n),
    .arrive  (ew_arrive),
    .lite    (EWLite),
    .fault   (fault_now),
    .count   (ew_count),
    .car     (EWCar),
    .ovf     (ew_ovf)
  );

  lane_queue #(
    .CNT_W         (CNT_W),
    .DEPART_CYCLES (DEPART_CYCLES)
  ) u_ns (
    .clock   (clock),
    .reset_n (reset_n),
    .arrive  (ns_arrive),
    .lite    (NSLite),
    .fault   (fault_now),
    .count   (ns_count),
    .car     (NSCar),
    .ovf     (ns_ovf)
  );

endmodule

// File: doc/traffic_queue_sensor.md
TRAFFIC_QUEUE_SENSOR -- requirements
Module: traffic_queue_sensor

Interface
REQ-001 Parameters SHALL be: CNT_W, default 4, queue counter width; DEPART_CYCLES, default 3, clocks of green per departing car (legal 1..15).
REQ-002 Ports SHALL be, in this order:
  clock  input  1  rising-edge clock;
  reset_n  input  1  asynchronous, active-low reset;
  ew_arrive  input  1  raw EW car-arrival sensor, asynchronous;
  ns_arrive  input  1  raw NS car-arrival sensor, asynchronous;
  EWLite  input  1  EW green from the light controller;
  NSLite  input  1  NS green from the light controller;
  EWCar  output  1  EW cars waiting;
  NSCar  output  1  NS cars waiting;
  ew_count  output  CNT_W  EW queue depth;
  ns_count  output  CNT_W  NS queue depth;
  ew_ovf  output  1  sticky EW overflow;
  ns_ovf  output  1  sticky NS overflow;
  lite_fault  output  1  sticky illegal-light flag.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low on reset_n.

Function
REQ-004 Each arrive input SHALL pass through a 2-flop synchronizer; one arrival SHALL be counted per rising edge of the synchronized signal.
REQ-005 A count increment SHALL become visible on the 3rd rising clock edge, counting the edge that first samples arrive high as edge 1.
REQ-006 A level held high for many cycles SHALL count as one arrival.
REQ-007 EWCar SHALL equal (ew_count != 0), and NSCar SHALL equal (ns_count != 0), combinationally.
REQ-008 Each lane SHALL run an FSM with two states, IDLE and SERVE.
  - IDLE -> SERVE when the lane's light = 1, count > 0 and no fault; timer loads DEPART_CYCLES-1.
REQ-009 In SERVE, the timer SHALL decrement each cycle.
  - At timer = 0, count decrements by 1.
  - If the light is still green and the new count > 0, the timer reloads and the FSM stays in SERVE; otherwise it goes to IDLE.
REQ-010 If the light drops, or a fault occurs, while in SERVE, the FSM SHALL return to IDLE next edge with no decrement, and the partial timer SHALL be discarded.
REQ-011 An arrival and a departure on the same edge SHALL leave the count unchanged.
REQ-012 Counts SHALL saturate at 2^CNT_W-1.
  - An arrival at saturation is dropped.
  - With OVF enabled, the lane's _ovf flag sets.
REQ-013 A count SHALL never decrement below 0.
REQ-014 lite_fault SHALL set on any edge where EWLite == NSLite and SHALL stay set until reset.
  - While EWLite == NSLite, no departures occur in either lane; arrivals still count.

Reset
REQ-015 On reset_n low, the following SHALL clear immediately, regardless of the clock: both counts = 0, both FSMs = IDLE, timers = 0, synchronizers and edge registers = 0, ew_ovf = ns_ovf = lite_fault = 0. EWCar and NSCar are consequently 0.
REQ-016 Reset asserted mid-SERVE SHALL abort the departure with no decrement.
REQ-017 Arrival edges SHALL NOT be detected on the first clock after reset release unless the synchronized input actually rises.

Configuration
REQ-018 Macro TRAFFIC_QUEUE_OVF_EN SHALL control the overflow feature.
  - Defined: ew_ovf and ns_ovf behave per REQ-012.
  - Undefined: ew_ovf and ns_ovf are tied 0, no overflow registers exist, and saturation still applies.

Structure
REQ-019 Shared package traffic_pkg SHALL hold:
  - lane_state_t enum {IDLE, SERVE};
  - default CNT_W;
  - default DEPART_CYCLES.
REQ-020 One sub-module, lane_queue, SHALL contain synchronizer, edge detect, counter, FSM and overflow for one lane; it SHALL be instantiated twice, and the top SHALL hold only fault logic.

Verification (CNT_W=4, DEPART_CYCLES=3)
REQ-021 The bench SHALL cover the following directed scenarios:
  - Single arrival: ew_arrive high 5 cycles, EWLite=0, NSLite=1 -> ew_count=1 at edge 3, EWCar=1, and it stays 1.
  - Service: ew_count=2, then EWLite=1, NSLite=0 -> count 1 after 3 edges, count 0 after 6 edges, EWCar=0, FSM back to IDLE.
  - Light drop: EWLite falls after 2 of 3 SERVE cycles -> ew_count unchanged.
  - Simultaneous events: arrival edge coincides with the departure edge -> ns_count holds its value.
  - Saturation: 16 arrivals with no green -> ew_count=15; with OVF_EN, ew_ovf=1 and sticky; without OVF_EN, ew_ovf=0.
  - Fault: EWLite=NSLite=1 for one cycle while serving -> lite_fault=1 until reset, no decrement during fault.
  - Reset: reset_n pulsed low mid-clock -> all outputs 0 before the next edge.
